// File: rtl/mux_sweep_ctrl.sv
// mux_sweep_ctrl: steps a 9-bit select/data vector through all 512 codes of
// an external mux circuit. Each vector is held for a settle (dwell) period,
// and then the circuit's 5-bit result is folded into a 16-bit MISR signature.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst_n        in   1   synchronous active-low reset
//   start        in   1   begin a sweep (honoured only in IDLE)
//   abort        in   1   terminate a sweep in progress
//   cfg          in   8   control-pin word, latched at start
//   dwell        in   4   settle cycles per vector, latched at start (0 -> 1)
//   res_in       in   5   mux circuit outputs {t,n,r,k,m}
//   vec          out  9   vector to the mux circuit {i..a}
//   ctrl_out     out  8   latched cfg
//   busy         out  1   high in DRIVE and SAMPLE
//   sample_valid out  1   high in the SAMPLE cycle of each vector
//   done         out  1   one-cycle pulse when a full sweep completes
//   sig          out  16  MISR signature
module mux_sweep_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  cfg,
  input  logic [3:0]  dwell,
  input  logic [4:0]  res_in,
  output logic [8:0]  vec,
  output logic [7:0]  ctrl_out,
  output logic        busy,
  output logic        sample_valid,
  output logic        done,
  output logic [15:0] sig
);

  localparam int unsigned VEC_W = 9;
  localparam int unsigned CFG_W = 8;
  localparam int unsigned DWL_W = 4;
  localparam int unsigned RES_W = 5;
  localparam int unsigned SIG_W = 16;
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(511);
  localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  logic [VEC_W-1:0]   r_vec;
  logic [CFG_W-1:0]   r_ctrl;
  logic [DWL_W-1:0]   r_dwell;
  logic [DWL_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_sample_valid;
  logic               r_done;
  logic [SIG_W-1:0]   r_sig;

  logic [SIG_W-1:0]   w_sig_next;
  logic               w_last_drive;

  // MISR: shift left, feed back the polynomial on bit 15, xor in the result
  assign w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
                    ^ (r_sig[SIG_W-1] ? MISR_POLY : SIG_W'(0))
                    ^ SIG_W'(res_in);

  // r_dwell is never 0 once latched, so dwell-1 cannot underflow in DRIVE
  assign w_last_drive = (r_cnt == (r_dwell - DWL_W'(1)));

  // Sweep state machine with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_vec          <= '0;
      r_ctrl         <= '0;
      r_dwell        <= '0;
      r_cnt          <= '0;
      r_busy         <= 1'b0;
      r_sample_valid <= 1'b0;
      r_done         <= 1'b0;
      r_sig          <= '0;
    end else begin
      r_sample_valid <= 1'b0;
      r_done         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_state <= S_DRIVE;
            r_vec   <= '0;
            r_ctrl  <= cfg;
            r_dwell <= (dwell == DWL_W'(0)) ? DWL_W'(1) : dwell;
            r_sig   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_DRIVE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + DWL_W'(1);
            if (w_last_drive) begin
              r_state        <= S_SAMPLE;
              r_sample_valid <= 1'b1;
            end
          end
        end
        S_SAMPLE: begin
          // abort wins over both the signature update and the transition
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_sig <= w_sig_next;
            if (r_vec == VEC_LAST) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_DRIVE;
              r_vec   <= r_vec + VEC_W'(1);
              r_cnt   <= '0;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign vec          = r_vec;
  assign ctrl_out     = r_ctrl;
  assign busy         = r_busy;
  assign sample_valid = r_sample_valid;
  assign done         = r_done;
  assign sig          = r_sig;

endmodule

// File: doc/mux_sweep_ctrl.md
MUX_SWEEP_CTRL -- requirements
Module: mux_sweep_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: start  input  1  one-cycle request to begin a sweep; sampled only in IDLE.
REQ-004 SHALL have port: abort  input  1  terminates a sweep in progress.
REQ-005 SHALL have port: cfg  input  8  control-pin word for the mux circuit (drives in1..in8), latched at start.
REQ-006 SHALL have port: dwell  input  4  settle cycles per vector, latched at start; 0 treated as 1.
REQ-007 SHALL have port: res_in  input  5  mux circuit outputs {t,n,r,k,m}, bit 4 = t.
REQ-008 SHALL have port: vec  output  9  select/data vector to the mux circuit {i,h,g,f,e,d,c,b,a}, bit 0 = a.
REQ-009 SHALL have port: ctrl_out  output  8  latched cfg, held for the whole sweep.
REQ-010 SHALL have port: busy  output  1  high in DRIVE and SAMPLE.
REQ-011 SHALL have port: sample_valid  output  1  high for the single SAMPLE cycle of each vector.
REQ-012 SHALL have port: done  output  1  one-cycle pulse on completion of a full sweep.
REQ-013 SHALL have port: sig  output  16  MISR signature of sampled results.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE; all outputs registered.
REQ-015 IDLE: start=1 and abort=0 -> DRIVE next cycle; vec<=0, ctrl_out<=cfg, dwell latched, sig<=16'h0000, internal dwell counter<=0.
REQ-016 IDLE: start=1 and abort=1 in the same cycle -> remain IDLE, no register change.
REQ-017 DRIVE: vec held; dwell counter increments each cycle; after effective-dwell cycles in DRIVE -> SAMPLE.
REQ-018 SAMPLE: lasts exactly one cycle; sample_valid=1; sig <= {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {11'b0,res_in}.
REQ-019 SAMPLE with vec != 9'd511 -> DRIVE, vec<=vec+1, dwell counter<=0.
REQ-020 SAMPLE with vec == 9'd511 -> DONE; vec stays 511 (no wrap).
REQ-021 DONE: done=1 for exactly one cycle, busy=0, then IDLE; sig and vec hold until the next start.
REQ-022 Per-sweep latency: (D+1)*512 cycles from the first DRIVE cycle to the DONE cycle, D = effective dwell.
REQ-023 abort=1 in DRIVE or SAMPLE -> IDLE next cycle; no done pulse; no sig update in that cycle; sig and vec hold their partial values.
REQ-024 abort has priority over the SAMPLE transition and the sig update in the same cycle.
REQ-025 start is ignored outside IDLE; start in the DONE cycle is ignored.
REQ-026 cfg, dwell and res_in changes outside latch/SAMPLE points SHALL NOT affect state.

Reset
REQ-027 rst_n=0 at a clock edge -> IDLE; vec=0, ctrl_out=0, busy=0, sample_valid=0, done=0, sig=0, dwell counter=0.
REQ-028 Reset SHALL override start and abort, and SHALL apply mid-sweep with no done pulse.

Verification
REQ-029 Reset: hold rst_n=0 for 2 cycles with start=1 -> all outputs 0, state IDLE, no busy.
REQ-030 Full sweep: dwell=1, cfg=8'hA5, res_in=0, start pulse -> ctrl_out=8'hA5, busy for 1024 cycles, 512 sample_valid pulses, done 1024 cycles after the first DRIVE cycle, sig=16'h0000, vec=511.
REQ-031 Dwell: dwell=0 behaves identically to dwell=1; dwell=3 -> done after 2048 cycles and vec steps every 4 cycles.
REQ-032 Signature: res_in=5'h01 on the first sample and 0 thereafter -> sig=16'h0001 after sample 1 and 16'h0002 after sample 2.
REQ-033 Abort: abort at vec=9'd100 during SAMPLE -> IDLE next cycle, no done pulse, vec=100, sig excludes sample 100; a later start restarts from vec=0 with sig=0.
REQ-034 Start handling: start asserted while busy -> no effect; start with abort in IDLE -> stays IDLE; rst_n=0 mid-sweep -> REQ-027 values.
